// File: rtl/prod_group_accumulator.sv
// Sums each group of N_TERMS valid products and presents the result on a valid/ready port.
// Optional ACC_SAT_EN: saturate the group sum on overflow and report it on ovf.
module prod_group_accumulator #(
  parameter int PROD_W  = 10,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf
);

  localparam int              CNT_W    = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] base_s, next_acc_s;
  logic             first_s, in_ready_s, take_s, done_s, abort_s;

`ifdef ACC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
  logic [ACC_W:0] sum_s;
  logic           next_sticky_s;
  logic           sticky_q, sticky_d;
  logic           ovf_q, ovf_d;
`endif

  // Next accumulator value if the presented product is taken; term 0 loads instead of adding.
  always_comb begin
    first_s = (count_q == '0);
    base_s  = first_s ? '0 : acc_q;
`ifdef ACC_SAT_EN
    sum_s = {1'b0, base_s} + SUM_W'(prod);
    if (sum_s[ACC_W]) begin
      next_acc_s = '1;
    end else begin
      next_acc_s = sum_s[ACC_W-1:0];
    end
    next_sticky_s = sum_s[ACC_W] | (~first_s & sticky_q);
`else
    next_acc_s = base_s + ACC_W'(prod);
`endif
  end

  // Group FSM: accumulate terms, then hold the result until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    in_ready_s  = 1'b1;
    take_s      = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready_s = 1'b1;
        if (clear) begin
          abort_s = 1'b1;
          count_d = '0;
          acc_d   = '0;
        end else if (in_valid) begin
          take_s = 1'b1;
          acc_d  = next_acc_s;
          if (count_q == LAST_CNT) begin
            done_s      = 1'b1;
            count_d     = '0;
            acc_out_d   = next_acc_s;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            count_d = count_q + ONE_CNT;
          end
        end else begin
          acc_d   = acc_q;
          count_d = count_q;
        end
      end
      HOLD: begin
        // clear is ignored here so a finished result is never lost
        in_ready_s = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
          if (in_valid) begin
            take_s  = 1'b1;
            acc_d   = next_acc_s;
            count_d = ONE_CNT;
          end else begin
            acc_d = acc_q;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ACCUM;
        count_d     = '0;
        acc_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ACC_SAT_EN
  // Sticky overflow follows the group; ovf is captured alongside acc_out.
  always_comb begin
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    if (abort_s) begin
      sticky_d = 1'b0;
    end else if (take_s) begin
      sticky_d = next_sticky_s;
    end else begin
      sticky_d = sticky_q;
    end
    if (done_s) begin
      ovf_d = next_sticky_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_s;
  assign acc_out   = acc_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prod_group_accumulator.sv
// Scoreboard bench: a 12-bit and an 11-bit accumulator share one stimulus stream.
module tb_prod_group_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  prod = 10'd0;
  logic        in_ready, out_valid, ovf;
  logic [11:0] acc_out;
  logic        in_ready_11, out_valid_11, ovf_11;
  logic [10:0] acc_out_11;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int a12;
    int a11;
    int ov;
  } exp_t;
  exp_t sb[$];

  bit m_hold;
  int m_cnt, m_a12, m_a11, m_ov;

  prod_group_accumulator #(.PROD_W(10), .N_TERMS(4), .ACC_W(12)) dut (
    .clk(clk), .reset(reset), .clear(clear), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .ovf(ovf)
  );

  prod_group_accumulator #(.PROD_W(10), .N_TERMS(4), .ACC_W(11)) dut_w11 (
    .clk(clk), .reset(reset), .clear(clear), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready_11), .acc_out(acc_out_11), .out_valid(out_valid_11),
    .out_ready(out_ready), .ovf(ovf_11)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, applied to the inputs just sampled.
  task automatic model_edge();
    int s;
    if (m_hold) begin
      if (out_ready) begin
        void'(sb.pop_front());
        m_hold = 1'b0;
        if (in_valid) begin
          m_cnt = 1;
          m_a12 = int'(prod);
          m_a11 = int'(prod);
          m_ov  = 0;
        end
      end
    end else if (clear) begin
      m_cnt = 0; m_a12 = 0; m_a11 = 0; m_ov = 0;
    end else if (in_valid) begin
      if (m_cnt == 0) begin
        m_a12 = 0; m_a11 = 0; m_ov = 0;
      end
      m_a12 = (m_a12 + int'(prod)) % 4096;
      s = m_a11 + int'(prod);
`ifdef ACC_SAT_EN
      if (s > 2047) begin
        s = 2047;
        m_ov = 1;
      end
`endif
      m_a11 = s % 2048;
      m_cnt++;
      if (m_cnt == 4) begin
        sb.push_back('{m_a12, m_a11, m_ov});
        m_hold = 1'b1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic step(input bit v, input int p, input bit clr, input bit ordy);
    logic [31:0] exp_ir;
    in_valid = v;
    prod = 10'(p);
    clear = clr;
    out_ready = ordy;
    @(negedge clk);
    exp_ir = m_hold ? 32'(ordy) : 32'd1;
    check_eq("in_ready", 32'(in_ready), exp_ir);
    check_eq("in_ready_w11", 32'(in_ready_11), exp_ir);
    check_eq("out_valid", 32'(out_valid), 32'(m_hold));
    check_eq("out_valid_w11", 32'(out_valid_11), 32'(m_hold));
    if (m_hold && sb.size() > 0) begin
      check_eq("acc_out", 32'(acc_out), 32'(sb[0].a12));
      check_eq("acc_out_w11", 32'(acc_out_11), 32'(sb[0].a11));
      check_eq("ovf", 32'(ovf), 32'd0);
      check_eq("ovf_w11", 32'(ovf_11), 32'(sb[0].ov));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    prod = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_hold = 1'b0; m_cnt = 0; m_a12 = 0; m_a11 = 0; m_ov = 0;
    sb.delete();
    check_eq("rst_acc_out", 32'(acc_out), 32'd0);
    check_eq("rst_acc_out_w11", 32'(acc_out_11), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ovf_w11", 32'(ovf_11), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    do_reset();

    // T1: back-to-back group
    step(1'b1, 10, 1'b0, 1'b1);
    step(1'b1, 20, 1'b0, 1'b1);
    step(1'b1, 30, 1'b0, 1'b1);
    step(1'b1, 40, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // T2: max products with idle gaps
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1023, 1'b0, 1'b1);
      for (int g = 0; g < i; g++) step(1'b0, 0, 1'b0, 1'b1);
    end
    step(1'b0, 0, 1'b0, 1'b1);

    // T3: backpressure, then handoff with simultaneous load
    for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 7, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // T4: clear discards partial group and same-cycle term; ignored in HOLD
    step(1'b1, 5, 1'b0, 1'b1);
    step(1'b1, 6, 1'b0, 1'b1);
    step(1'b1, 9, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);

    // T5: overflow of the 11-bit accumulator, then a clean group
    for (int i = 0; i < 4; i++) step(1'b1, 1023, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // T6: reset mid-group
    step(1'b1, 3, 1'b0, 1'b1);
    step(1'b1, 3, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    for (int i = 0; i < 8 && sb.size() > 0; i++) step(1'b0, 0, 1'b0, 1'b1);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
